// File: rtl/apb_regfile_slave_if.sv
// ----------------------------------------------------------------------------
// apb_regfile_slave_if
// APB3 bus bundle between a requester and apb_regfile_slave.
//   paddr   : byte address            (requester -> completer)
//   pwdata  : write data              (requester -> completer)
//   pwrite  : 1 = write, 0 = read     (requester -> completer)
//   psel    : select                  (requester -> completer)
//   penable : access phase            (requester -> completer)
//   pready  : transfer completes      (completer -> requester)
//   prdata  : read data               (completer -> requester)
//   pslverr : error response          (completer -> requester)
// ----------------------------------------------------------------------------
interface apb_regfile_slave_if;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output pready, prdata, pslverr
  );

  modport master (
    output paddr, pwdata, pwrite, psel, penable,
    input  pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_regfile_slave.sv
// ----------------------------------------------------------------------------
// apb_regfile_slave
// APB3 completer holding DEPTH read/write 32-bit registers plus a read-only
// 16-bit transfer counter at the word just above the register bank. Each
// access phase is stretched by WAIT_STATES cycles; bad decodes answer with
// pslverr.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   bus       : APB3 slave modport (paddr/pwdata/pwrite/psel/penable in,
//               pready/prdata/pslverr out)
//   dbg_state : 1 while the FSM is in ACCESS, 0 in IDLE
// ----------------------------------------------------------------------------
// Handshake: a transfer starts with a setup cycle (psel=1, penable=0) and
// continues with access cycles (psel=1, penable=1). pready is the completer's
// "done" strobe; the transfer commits on the rising edge where
// psel & penable & pready are all 1. prdata/pslverr are meaningful only in
// that pready cycle and are forced to 0 otherwise. Dropping psel before
// pready abandons the transfer with no side effect.
module apb_regfile_slave #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  apb_regfile_slave_if.slave bus,
  output logic               dbg_state
);

  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] CNT_OFF   = 32'(DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [3:0]       wait_cnt, wait_cnt_nxt;
  logic [31:0]      regs [DEPTH];
  logic [15:0]      txn_cnt;

  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic             is_cnt;
  logic             dec_err;
  logic             ready_int;
  logic             complete;
  logic             do_write;
  logic [31:0]      rd_word;

  // Word offset from the bank base. An address below BASE_ADDR wraps to a
  // huge offset and therefore lands in the error range.
  assign off    = (bus.paddr - BASE_ADDR) >> 2;
  assign idx    = off[IDX_W-1:0];
  assign is_cnt = (off == CNT_OFF);

  assign dec_err = (bus.paddr[1:0] != 2'b00) || (off > CNT_OFF) ||
                   (is_cnt && bus.pwrite);

  assign rd_word = is_cnt ? {16'h0, txn_cnt} : regs[idx];

  // pready comes purely from registered state, so it never depends
  // combinationally on the requester's inputs.
  assign ready_int = (state == ACCESS) && (wait_cnt == 4'd0);
  assign complete  = ready_int && bus.psel && bus.penable;
  assign do_write  = complete && bus.pwrite && !dec_err;

  assign bus.pready  = ready_int;
  assign bus.pslverr = ready_int && dec_err;
  assign bus.prdata  = (ready_int && !bus.pwrite && !dec_err) ? rd_word : 32'h0;

  assign dbg_state = (state == ACCESS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        // An enable without a preceding setup is ignored.
        if (bus.psel && !bus.penable) begin
          state_nxt    = ACCESS;
          wait_cnt_nxt = WAIT_INIT;
        end
      end
      ACCESS: begin
        if (!bus.psel) begin
          state_nxt = IDLE;
        end else if (bus.penable) begin
          if (wait_cnt != 4'd0) begin
            wait_cnt_nxt = wait_cnt - 4'd1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register bank and transfer counter. The counter increments on every
  // completion, errors included, and wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= 32'h0;
      end
      txn_cnt <= 16'h0;
    end else begin
      if (do_write) begin
        regs[idx] <= bus.pwdata;
      end
      if (complete) begin
        txn_cnt <= txn_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// ----------------------------------------------------------------------------
// tb_apb_regfile_slave
// Two completers share clock and reset: dut2 (WAIT_STATES=2) and dut0
// (WAIT_STATES=0), both with DEPTH=16 at BASE=0x1000. Driver tasks push the
// expected {pslverr, prdata} for each issued transfer; per-bus monitors pop
// and compare whenever pready is seen.
// ----------------------------------------------------------------------------
module tb_apb_regfile_slave;

  localparam logic [31:0] BASE     = 32'h0000_1000;
  localparam int          DEPTH    = 16;
  localparam logic [31:0] CNT_ADDR = BASE + 32'(DEPTH * 4);
  localparam logic [31:0] OOR_ADDR = BASE + 32'((DEPTH + 1) * 4);
  localparam int          MAX_WAIT = 20;
  localparam int          W        = 33;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_regfile_slave_if bus2();
  apb_regfile_slave_if bus0();
  logic dbg2, dbg0;

  apb_regfile_slave #(.DEPTH(DEPTH), .WAIT_STATES(2), .BASE_ADDR(BASE)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .dbg_state(dbg2)
  );

  apb_regfile_slave #(.DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .dbg_state(dbg0)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q2[$];
  logic [W-1:0] exp_q0[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon2
    logic [W-1:0] e;
    if (bus2.pready === 1'b1) begin
      if (exp_q2.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon2_unexpected: pready with nothing expected, prdata %08h", bus2.prdata);
      end else begin
        e = exp_q2.pop_front();
        check("mon2_pslverr", {31'h0, bus2.pslverr}, {31'h0, e[32]});
        check("mon2_prdata", bus2.prdata, e[31:0]);
      end
    end else if (rst === 1'b1 && (bus2.pslverr !== 1'b0 || bus2.prdata !== 32'h0)) begin
      tests++;
      fails++;
      $display("FAIL mon2_idle_outputs: pslverr %0b prdata %08h expected 0 0", bus2.pslverr, bus2.prdata);
    end
  end

  always @(negedge clk) begin : mon0
    logic [W-1:0] e;
    if (bus0.pready === 1'b1) begin
      if (exp_q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon0_unexpected: pready with nothing expected, prdata %08h", bus0.prdata);
      end else begin
        e = exp_q0.pop_front();
        check("mon0_pslverr", {31'h0, bus0.pslverr}, {31'h0, e[32]});
        check("mon0_prdata", bus0.prdata, e[31:0]);
      end
    end else if (rst === 1'b1 && (bus0.pslverr !== 1'b0 || bus0.prdata !== 32'h0)) begin
      tests++;
      fails++;
      $display("FAIL mon0_idle_outputs: pslverr %0b prdata %08h expected 0 0", bus0.pslverr, bus0.prdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_bus(input int d, input logic sel, input logic en, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
    if (d == 2) begin
      bus2.psel = sel; bus2.penable = en; bus2.pwrite = wr;
      bus2.paddr = addr; bus2.pwdata = data;
    end else begin
      bus0.psel = sel; bus0.penable = en; bus0.pwrite = wr;
      bus0.paddr = addr; bus0.pwdata = data;
    end
  endtask

  function automatic logic get_pready(input int d);
    return (d == 2) ? bus2.pready : bus0.pready;
  endfunction

  // Called just after a rising edge; the setup phase occupies the current
  // cycle, so consecutive calls are back-to-back with no idle cycle.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic exp_err,
                      input logic [31:0] exp_rd, input string name);
    int acc;
    int ws;
    ws = (d == 2) ? 2 : 0;
    if (d == 2) exp_q2.push_back({exp_err, exp_rd});
    else        exp_q0.push_back({exp_err, exp_rd});
    set_bus(d, 1'b1, 1'b0, wr, addr, data);
    @(posedge clk); #1;
    set_bus(d, 1'b1, 1'b1, wr, addr, data);
    acc = 1;
    forever begin
      @(negedge clk);
      if (get_pready(d) === 1'b1) break;
      if (acc >= MAX_WAIT) break;
      acc++;
    end
    check({name, "_latency"}, 32'(acc), 32'(ws + 1));
    @(posedge clk); #1;
    set_bus(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    summary();
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    set_bus(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_bus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pready2",  {31'h0, bus2.pready},  32'h0);
    check("reset_pslverr2", {31'h0, bus2.pslverr}, 32'h0);
    check("reset_prdata2",  bus2.prdata,           32'h0);
    check("reset_pready0",  {31'h0, bus0.pready},  32'h0);
    check("reset_state0",   {31'h0, dbg0},         32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // dut2: write then read reg 3 before the mid-transfer reset
    xfer(2, 1'b1, BASE + 32'h0C, 32'h1234_5678, 1'b0, 32'h0, "w2_reg3");
    xfer(2, 1'b0, BASE + 32'h0C, 32'h0, 1'b0, 32'h1234_5678, "r2_reg3");

    // reset during the cycle where pready would have risen
    set_bus(2, 1'b1, 1'b0, 1'b1, BASE + 32'h0C, 32'hFFFF_0000);
    @(posedge clk); #1;
    set_bus(2, 1'b1, 1'b1, 1'b1, BASE + 32'h0C, 32'hFFFF_0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_pready",  {31'h0, bus2.pready},  32'h0);
    check("midrst_pslverr", {31'h0, bus2.pslverr}, 32'h0);
    check("midrst_prdata",  bus2.prdata,           32'h0);
    check("midrst_state",   {31'h0, dbg2},         32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    set_bus(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;

    xfer(2, 1'b0, CNT_ADDR, 32'h0, 1'b0, 32'h0, "r2_cnt_after_rst");
    xfer(2, 1'b0, BASE + 32'h0C, 32'h0, 1'b0, 32'h0, "r2_reg3_after_rst");

    // wait-state write/readback
    xfer(2, 1'b1, BASE + 32'h08, 32'hDEAD_BEEF, 1'b0, 32'h0, "w2_reg2");
    xfer(2, 1'b0, BASE + 32'h08, 32'h0, 1'b0, 32'hDEAD_BEEF, "r2_reg2");

    // decode errors
    xfer(2, 1'b1, BASE + 32'h02, 32'hAAAA_AAAA, 1'b1, 32'h0, "err_unaligned");
    xfer(2, 1'b1, CNT_ADDR, 32'h5555_5555, 1'b1, 32'h0, "err_cnt_write");
    xfer(2, 1'b0, OOR_ADDR, 32'h0, 1'b1, 32'h0, "err_oor_read");

    // last register, untouched reg 0, counter after errors
    xfer(2, 1'b1, BASE + 32'h3C, 32'hCAFE_F00D, 1'b0, 32'h0, "w2_reg15");
    xfer(2, 1'b0, BASE + 32'h3C, 32'h0, 1'b0, 32'hCAFE_F00D, "r2_reg15");
    xfer(2, 1'b0, BASE + 32'h00, 32'h0, 1'b0, 32'h0, "r2_reg0_untouched");
    xfer(2, 1'b0, CNT_ADDR, 32'h0, 1'b0, 32'h0000_000A, "r2_cnt_10");

    // abort after one access cycle
    set_bus(2, 1'b1, 1'b0, 1'b1, BASE + 32'h08, 32'h0BAD_0BAD);
    @(posedge clk); #1;
    set_bus(2, 1'b1, 1'b1, 1'b1, BASE + 32'h08, 32'h0BAD_0BAD);
    @(negedge clk);
    check("abort_no_ready", {31'h0, bus2.pready}, 32'h0);
    @(posedge clk); #1;
    set_bus(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    xfer(2, 1'b0, BASE + 32'h08, 32'h0, 1'b0, 32'hDEAD_BEEF, "r2_reg2_after_abort");
    xfer(2, 1'b0, CNT_ADDR, 32'h0, 1'b0, 32'h0000_000C, "r2_cnt_after_abort");

    // dut0: back-to-back zero-wait writes
    xfer(0, 1'b1, BASE + 32'h00, 32'h1111_1111, 1'b0, 32'h0, "b2b_w0");
    xfer(0, 1'b1, BASE + 32'h04, 32'h2222_2222, 1'b0, 32'h0, "b2b_w1");
    xfer(0, 1'b1, BASE + 32'h10, 32'h3333_3333, 1'b0, 32'h0, "b2b_w4");
    xfer(0, 1'b1, BASE + 32'h14, 32'h4444_4444, 1'b0, 32'h0, "b2b_w5");
    xfer(0, 1'b0, CNT_ADDR, 32'h0, 1'b0, 32'h0000_0004, "b2b_cnt4");
    xfer(0, 1'b0, BASE + 32'h10, 32'h0, 1'b0, 32'h3333_3333, "b2b_r4");

    // enable without setup must be ignored
    set_bus(0, 1'b1, 1'b1, 1'b1, BASE + 32'h04, 32'hBAD0_BAD0);
    @(negedge clk);
    check("noset_pready_a", {31'h0, bus0.pready}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("noset_pready_b", {31'h0, bus0.pready}, 32'h0);
    check("noset_state",    {31'h0, dbg0},        32'h0);
    @(posedge clk); #1;
    set_bus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    xfer(0, 1'b0, CNT_ADDR, 32'h0, 1'b0, 32'h0000_0006, "noset_cnt6");
    xfer(0, 1'b0, BASE + 32'h04, 32'h0, 1'b0, 32'h2222_2222, "noset_r1");

    // counter wrap: preload 0xFFFF instead of issuing 65535 transfers
    force dut0.txn_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut0.txn_cnt;
    @(posedge clk); #1;
    xfer(0, 1'b0, CNT_ADDR, 32'h0, 1'b0, 32'h0000_FFFF, "wrap_ffff");
    xfer(0, 1'b0, CNT_ADDR, 32'h0, 1'b0, 32'h0000_0000, "wrap_zero");

    repeat (3) @(posedge clk);
    check("q2_drained", 32'(exp_q2.size()), 32'h0);
    check("q0_drained", 32'(exp_q0.size()), 32'h0);
    summary();
    $finish;
  end

endmodule
